// File: rtl/fetch_pred_pkg.sv
// Shared fetch/branch-prediction types: branch kinds, BTB entry layout, counter helpers.
// BTB_DEF_* describe the default geometry; fetch_btb derives its own widths from ENTRIES.
package fetch_pred_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JALR = 2'b01,
    BR_JAL  = 2'b11
  } br_type_t;

  localparam int BTB_DEF_ENTRIES = 16;
  localparam int BTB_DEF_IDX_W   = $clog2(BTB_DEF_ENTRIES);
  localparam int BTB_DEF_TAG_W   = 30 - BTB_DEF_IDX_W;

  typedef struct packed {
    logic                     valid;
    logic [BTB_DEF_TAG_W-1:0] tag;
    logic [29:0]              target;
    logic [1:0]               ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped BTB with 2-bit counters. Read port: fetch word PC -> taken/target.
// Write port: execute word PC with kind/taken/target; updates on the clock edge.
module fetch_btb
  import fetch_pred_pkg::*;
#(
  parameter int ENTRIES      = 16,
  parameter bit PREDICT_JALR = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_pc,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  br_type_t    wr_kind,
  input  logic [29:0] wr_pc,
  input  logic        wr_taken,
  input  logic [29:0] wr_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic          vld [ENTRIES];
  logic [1:0]    ctr [ENTRIES];
  logic [TW-1:0] tag [ENTRIES];
  logic [29:0]   tgt [ENTRIES];

  logic [IW-1:0] ri;
  logic [IW-1:0] wi;
  logic [TW-1:0] rt;
  logic [TW-1:0] wt;
  logic          w_hit;
  logic          kind_ok;
  logic          upd_take;
  logic          upd_dec;

  assign ri = rd_pc[IW-1:0];
  assign rt = rd_pc[29:IW];
  assign wi = wr_pc[IW-1:0];
  assign wt = wr_pc[29:IW];

  // Reads see pre-edge contents, so a same-cycle write returns old data.
  assign rd_taken  = vld[ri] & (tag[ri] == rt) & ctr[ri][1];
  assign rd_target = {tgt[ri], 2'b00};

  assign w_hit = vld[wi] & (tag[wi] == wt);

  always_comb begin
    kind_ok = 1'b0;
    unique case (1'b1)
      (wr_kind == BR_COND): kind_ok = 1'b1;
      (wr_kind == BR_JAL):  kind_ok = 1'b1;
      (wr_kind == BR_JALR): kind_ok = PREDICT_JALR;
      default:              kind_ok = 1'b0;
    endcase
  end

  assign upd_take = wr_en & wr_taken & kind_ok;
  assign upd_dec  = wr_en & ~wr_taken & (wr_kind == BR_COND) & w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld[i] <= 1'b0;
        ctr[i] <= 2'b01;
      end
    end else if (upd_take) begin
      vld[wi] <= 1'b1;
      ctr[wi] <= w_hit ? ctr_inc(ctr[wi]) : 2'b10;
    end else if (upd_dec) begin
      ctr[wi] <= ctr_dec(ctr[wi]);
    end
  end

  // Tag/target need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (upd_take) begin
      tag[wi] <= wt;
      tgt[wi] <= wr_target;
    end
  end

endmodule

// File: rtl/fetch_pred.sv
// Branch-predicting fetch stage: PC_f/PC_e, BTB lookup, execute-stage resolution.
// Ports: clk/rst, fetch_stall, branch inputs, i_addr/PC_f/PC_e, flush, mispredict_cnt.
module fetch_pred
  import fetch_pred_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter int          BTB_ENTRIES  = 16,
  parameter bit          PREDICT_JALR = 1'b0,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_stall,
  input  logic             is_br_type,
  input  br_type_t         br_type,
  input  logic             take_branch,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      imm_b,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      imm_j,
  output logic [31:0]      i_addr,
  output logic [31:0]      PC_f,
  output logic [31:0]      PC_e,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        active;
  logic        taken;
  logic [31:0] target;
  logic        mispred;
  logic        redirect;
  logic [31:0] next_pc;

  fetch_btb #(
    .ENTRIES      (BTB_ENTRIES),
    .PREDICT_JALR (PREDICT_JALR)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (PC_f[31:2]),
    .rd_taken  (pred_taken_f),
    .rd_target (pred_target_f),
    .wr_en     (active),
    .wr_kind   (br_type),
    .wr_pc     (PC_e[31:2]),
    .wr_taken  (taken),
    .wr_target (target[31:2])
  );

  // The instruction in execute during a flush cycle is dead.
  always_comb begin
    active = 1'b0;
    taken  = 1'b0;
    target = '0;
    if (is_br_type && !flush) begin
      case (br_type)
        BR_COND: begin
          active = 1'b1;
          taken  = take_branch;
          target = PC_e + imm_b;
        end
        BR_JAL: begin
          active = 1'b1;
          taken  = 1'b1;
          target = PC_e + imm_j;
        end
        BR_JALR: begin
          active = 1'b1;
          taken  = 1'b1;
          target = (rs1_data + imm_i) & ~32'd1;
        end
        default: ;
      endcase
    end
  end

  assign mispred  = (taken != pred_taken_e)
                  | (taken & (target != pred_target_e));
  assign redirect = active & mispred;

  always_comb begin
    if (redirect)
      next_pc = taken ? target : PC_e + 32'd4;
    else
      next_pc = pred_taken_f ? pred_target_f : PC_f + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_f           <= RESET_PC;
      PC_e           <= '0;
      pred_taken_e   <= 1'b0;
      pred_target_e  <= '0;
      flush          <= 1'b1;
      mispredict_cnt <= '0;
    end else begin
      if (redirect || !fetch_stall)
        PC_f <= next_pc;
      PC_e          <= PC_f;
      pred_taken_e  <= pred_taken_f;
      pred_target_e <= pred_target_f;
      flush         <= redirect;
      if (redirect && !(&mispredict_cnt))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign i_addr = PC_f;

endmodule

// File: tb/tb_fetch_pred.sv
// Testbench for fetch_pred (4-entry BTB, 3-bit counter): table of per-cycle
// stimulus with expected PCs, expectations queued and compared after each edge.
module tb_fetch_pred;
  import fetch_pred_pkg::*;

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] M16 = 32'hFFFF_FFF0;
  localparam logic [31:0] M4 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_stall = 1'b0;
  logic        is_br_type = 1'b0;
  br_type_t    br_type = BR_COND;
  logic        take_branch = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] imm_b = '0;
  logic [31:0] imm_i = '0;
  logic [31:0] imm_j = '0;
  logic [31:0] i_addr;
  logic [31:0] PC_f;
  logic [31:0] PC_e;
  logic        flush;
  logic [2:0]  mispredict_cnt;

  fetch_pred #(
    .RESET_PC     (B),
    .BTB_ENTRIES  (4),
    .PREDICT_JALR (1'b0),
    .CNT_W        (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_stall    (fetch_stall),
    .is_br_type     (is_br_type),
    .br_type        (br_type),
    .take_branch    (take_branch),
    .rs1_data       (rs1_data),
    .imm_b          (imm_b),
    .imm_i          (imm_i),
    .imm_j          (imm_j),
    .i_addr         (i_addr),
    .PC_f           (PC_f),
    .PC_e           (PC_e),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        isbr;
    logic [1:0]  bt;
    logic        take;
    logic [31:0] rs1;
    logic [31:0] ib;
    logic [31:0] ii;
    logic [31:0] ij;
    logic [31:0] pcf;
    logic [31:0] pce;
    logic        fl;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] pce;
    logic        fl;
    logic [2:0]  cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t br(input logic stall, input logic [1:0] bt,
                              input logic take, input logic [31:0] rs1,
                              input logic [31:0] ib, input logic [31:0] ii,
                              input logic [31:0] ij, input logic [31:0] pcf,
                              input logic [31:0] pce, input logic fl,
                              input logic [2:0] cnt);
    vec_t v;
    v.stall = stall; v.isbr = 1'b1; v.bt = bt; v.take = take;
    v.rs1 = rs1; v.ib = ib; v.ii = ii; v.ij = ij;
    v.pcf = pcf; v.pce = pce; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t nb(input logic stall, input logic [31:0] pcf,
                              input logic [31:0] pce, input logic fl,
                              input logic [2:0] cnt);
    vec_t v;
    v = br(stall, 2'b00, 1'b0, '0, '0, '0, '0, pcf, pce, fl, cnt);
    v.isbr = 1'b0;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    exp_t e;
    fetch_stall = v.stall;
    is_br_type  = v.isbr;
    br_type     = br_type_t'(v.bt);
    take_branch = v.take;
    rs1_data    = v.rs1;
    imm_b       = v.ib;
    imm_i       = v.ii;
    imm_j       = v.ij;
    e.pcf = v.pcf; e.pce = v.pce; e.fl = v.fl; e.cnt = v.cnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got 0 want 1", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " PC_f"}, PC_f, e.pcf);
      chk({nm, " i_addr"}, i_addr, e.pcf);
      chk({nm, " PC_e"}, PC_e, e.pce);
      chk({nm, " flush"}, {31'd0, flush}, {31'd0, e.fl});
      chk({nm, " cnt"}, {29'd0, mispredict_cnt}, {29'd0, e.cnt});
    end
  endtask

  initial begin
    // sequential fetch; br_type 2'b10 is not a branch
    tbl.push_back(nb(0, B+4, B, 0, 0));
    tbl.push_back(br(0, 2'b10, 1, '0, 32'h40, '0, '0, B+8, B+4, 0, 0));
    tbl.push_back(nb(0, B+'hC, B+8, 0, 0));
    tbl.push_back(nb(0, B+'h10, B+'hC, 0, 0));
    tbl.push_back(nb(0, B+'h14, B+'h10, 0, 0));
    // first pass of backward branch: redirect + flush
    tbl.push_back(br(0, 2'b00, 1, '0, M16, '0, '0, B, B+'h14, 1, 1));
    // resolution suppressed under flush
    tbl.push_back(br(0, 2'b00, 1, '0, M16, '0, '0, B+4, B, 0, 1));
    tbl.push_back(nb(0, B+8, B+4, 0, 1));
    tbl.push_back(nb(0, B+'hC, B+8, 0, 1));
    tbl.push_back(nb(0, B+'h10, B+'hC, 0, 1));
    // second pass predicted in fetch
    tbl.push_back(nb(0, B, B+'h10, 0, 1));
    tbl.push_back(br(0, 2'b00, 1, '0, M16, '0, '0, B+4, B, 0, 1));
    tbl.push_back(nb(0, B+8, B+4, 0, 1));
    tbl.push_back(nb(0, B+'hC, B+8, 0, 1));
    tbl.push_back(nb(0, B+'h10, B+'hC, 0, 1));
    tbl.push_back(nb(0, B, B+'h10, 0, 1));
    tbl.push_back(br(0, 2'b00, 1, '0, M16, '0, '0, B+4, B, 0, 1));
    tbl.push_back(nb(0, B+8, B+4, 0, 1));
    tbl.push_back(nb(0, B+'hC, B+8, 0, 1));
    tbl.push_back(nb(0, B+'h10, B+'hC, 0, 1));
    tbl.push_back(nb(0, B, B+'h10, 0, 1));
    // loop exit mispredicts to PC_e+4
    tbl.push_back(br(0, 2'b00, 0, '0, M16, '0, '0, B+'h14, B, 1, 2));
    tbl.push_back(nb(0, B+'h18, B+'h14, 0, 2));
    // JAL back to the loop branch
    tbl.push_back(br(0, 2'b11, 0, '0, '0, '0, M4, B+'h10, B+'h18, 1, 3));
    // ctr 2'b10 still predicts taken; flushed resolution ignored
    tbl.push_back(br(0, 2'b00, 1, '0, 32'h100, '0, '0, B, B+'h10, 0, 3));
    tbl.push_back(br(0, 2'b00, 1, '0, M16, '0, '0, B+4, B, 0, 3));
    // JALR clears bit 0, no BTB allocation
    tbl.push_back(br(0, 2'b01, 0, B+'h101, '0, 32'd2, '0,
                     B+'h102, B+4, 1, 4));
    tbl.push_back(nb(0, B+'h106, B+'h102, 0, 4));
    tbl.push_back(br(0, 2'b01, 0, B, '0, '0, '0, B, B+'h106, 1, 5));
    tbl.push_back(nb(0, B+4, B, 0, 5));
    // redirect wins over fetch_stall
    tbl.push_back(nb(1, B+4, B+4, 0, 5));
    tbl.push_back(br(1, 2'b00, 1, '0, 32'h20, '0, '0, B+'h24, B+4, 1, 6));
    tbl.push_back(nb(1, B+'h24, B+'h24, 0, 6));
    // aliasing: 0x..00 replaces the 0x..10 entry; counter saturates at 7
    tbl.push_back(br(0, 2'b01, 0, B, '0, '0, '0, B, B+'h24, 1, 7));
    tbl.push_back(nb(0, B+4, B, 0, 7));
    tbl.push_back(br(0, 2'b11, 0, '0, '0, '0, 32'h10, B+'h10, B+4, 1, 7));
    tbl.push_back(nb(0, B+'h14, B+'h10, 0, 7));
    tbl.push_back(nb(0, B+'h18, B+'h14, 0, 7));

    @(negedge clk);
    chk("rst PC_f", PC_f, B);
    chk("rst i_addr", i_addr, B);
    chk("rst PC_e", PC_e, 32'd0);
    chk("rst flush", {31'd0, flush}, 32'd1);
    chk("rst cnt", {29'd0, mispredict_cnt}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("r%0d", i + 1));

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst PC_f", PC_f, B);
    chk("arst PC_e", PC_e, 32'd0);
    chk("arst flush", {31'd0, flush}, 32'd1);
    chk("arst cnt", {29'd0, mispredict_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // BTB valid cleared: 0x..00 no longer predicts
    step(nb(0, B+4, B, 0, 0), "post_rst");
    step(nb(0, B+8, B+4, 0, 0), "post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pred.md
# fetch_pred

Branch-predicting successor to the current fetch stage. It holds the fetch and execute PCs and drives the instruction-memory address. A parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters lets the stage redirect speculatively in the fetch cycle. When the execute stage resolves a branch or jump differently from the prediction, the stage corrects the PC and raises a one-cycle flush.

## Interface
- RESET_PC, 32'h8000_0000, PC_f value after reset
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256
- PREDICT_JALR, 0, 1 = JALR targets are also allocated/predicted
- CNT_W, 32, width of mispredict performance counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_stall  in  1  hold PC_f (ignored during a redirect)
- is_br_type  in  1  execute-stage instruction is branch/jump
- br_type  in  br_type_t  BR_COND / BR_JALR / BR_JAL
- take_branch  in  1  conditional-branch outcome (BR_COND only)
- rs1_data  in  32  JALR base
- imm_b, imm_i, imm_j  in  32 each  sign-extended immediates
- i_addr  out  32  instruction memory address (= PC_f)
- PC_f  out  32  fetch-stage PC
- PC_e  out  32  execute-stage PC
- flush  out  1  kill the instructions younger than execute
- mispredict_cnt  out  CNT_W  saturating count of redirects

## Operation
- Index is PC_f[IDX+1:2], where IDX = log2(BTB_ENTRIES). Tag is PC_f[31:IDX+2].
- Each entry holds valid, tag, target[31:2], and ctr[1:0].
- pred_taken_f = valid & tag match & ctr[1]. pred_target_f = {target, 2'b00}.
- Default next PC: pred_taken_f ? pred_target_f : PC_f+4.
- pred_taken_e and pred_target_e are registered alongside PC_e every cycle.
- Resolution in execute is active when is_br_type=1 and flush=0:
  - BR_COND: taken = take_branch; target = PC_e+imm_b.
  - BR_JAL: taken = 1; target = PC_e+imm_j.
  - BR_JALR: taken = 1; target = (rs1_data+imm_i) & ~1.
  - Any other br_type value counts as not a branch.
- Without an active resolution, taken = 0.
- Mispredict = (taken != pred_taken_e) | (taken & target != pred_target_e).
- A mispredict with an active resolution is a redirect.
- On a redirect:
  - next PC = taken ? target : PC_e+4.
  - PC_f loads next PC even when fetch_stall=1.
  - mispredict_cnt increments, saturating at all-ones.
- BTB update happens on the clock edge that ends an active resolution, at the entry indexed by PC_e.
- BR_COND or BR_JAL taken:
  - Tag hit: ctr increments (saturating at 3) and target is rewritten.
  - Tag miss or invalid: the entry is allocated with valid=1, the new tag and target, and ctr=2'b10.
- BR_COND not taken: on a tag hit, ctr decrements (saturating at 0); on a miss, no change.
- BR_JALR follows the taken rule only if PREDICT_JALR=1; otherwise the BTB is untouched.
- Read/write collision: a fetch read of the entry being written in the same cycle returns the old contents.

## Timing
- Reset values:
  - PC_f = RESET_PC, PC_e = 0, pred_*_e = 0, flush = 1, mispredict_cnt = 0.
  - All BTB valid bits = 0, all ctr = 2'b01.
  - The BTB tag and target arrays need no reset.
- PC_f updates on every edge unless fetch_stall=1 and there is no redirect.
- PC_e <= PC_f on every edge, regardless of fetch_stall.
- Redirect latency:
  - Resolution in cycle N gives PC_f = corrected PC in cycle N+1.
  - flush = 1 in cycle N+1 only; flush <= redirect is registered.
- Correctly predicted taken branch: zero bubbles; no flush.
- While flush=1, resolution is suppressed: no redirect, no BTB update, no count.
- An asynchronous reset mid-operation returns every output to its reset value immediately; pending updates are lost.

## Structure
- br_type_t and BR_COND=2'b00, BR_JALR=2'b01, BR_JAL=2'b11 stay in the shared defines package.
- Add btb_entry_t (valid, tag, target, ctr) to the package, parametrised via localparams derived from BTB_ENTRIES.
- Sub-module fetch_btb holds the storage, the lookup, and the counter-update logic:
  - Read port: PC_f.
  - Write port: PC_e with taken/target/kind.
- fetch_pred keeps the PC registers, the resolution logic, the flush, and the counter.

## Test plan
- Reset, no branches: PC_f = 0x80000000, then 0x80000004, 0x80000008; flush=1 in the first cycle only.
- BR_COND taken at 0x80000010 with imm_b = -16, executed twice:
  - First pass: redirect to 0x80000000, flush pulse, mispredict_cnt=1.
  - Second pass: predicted in fetch (PC_f goes 0x80000010 to 0x80000000 directly); no flush; count stays 1.
- Loop branch taken 3 times, then not taken:
  - The exit mispredicts, redirects to 0x80000014, and leaves ctr=2'b10.
  - A further taken pass predicts taken.
- JALR with rs1_data=0x80000101, imm_i=2 (PREDICT_JALR=0): redirect target 0x80000102 (bit 0 cleared); BTB unchanged.
- fetch_stall=1 held during a mispredict: PC_f still takes the redirect target next cycle; flush=1.
- Aliasing, BTB_ENTRIES=4: PCs 0x80000000 and 0x80000010 share an index:
  - The second allocation replaces the first.
  - The first PC then misses (predicts PC+4).
